// File: rtl/instr_fetch.sv
// Instruction fetch unit: a PC register feeding a two-entry in-order buffer.
// Redirects flush the buffer, and an out-of-range redirect target sets a sticky fault.
module instr_fetch #(
    parameter int         MEM_DEPTH = 32,
    parameter logic [7:0] RESET_PC  = 8'h00
) (
    input  logic       clk,
    input  logic       clear,
    output logic [7:0] address,
    input  logic [7:0] instruction,
    input  logic       halt,
    input  logic       redirect,
    input  logic [7:0] redirect_target,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_instruction,
    output logic [7:0] out_pc,
    output logic       fault
);

    localparam logic [8:0] DEPTH   = 9'(MEM_DEPTH);
    localparam logic [7:0] LAST_PC = 8'(MEM_DEPTH - 1);

    logic [7:0] pc;
    logic [7:0] tail_instruction;
    logic [7:0] tail_pc;
    logic [1:0] count;
    logic       pop;
    logic       push;
    logic       target_ok;

    assign address   = pc;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign push      = !halt && !redirect && !fault && ((count < 2'd2) || pop);
    assign target_ok = {1'b0, redirect_target} < DEPTH;

    always_ff @(posedge clk) begin
        if (clear) begin
            pc    <= RESET_PC;
            fault <= 1'b0;
        end else if (redirect) begin
            if (target_ok) begin
                pc <= redirect_target;
            end else begin
                fault <= 1'b1;
            end
        end else if (push) begin
            pc <= (pc == LAST_PC) ? 8'h00 : pc + 8'd1;
        end
    end

    // Head lives in the output registers; the tail slot only fills when the head is occupied.
    always_ff @(posedge clk) begin
        if (clear) begin
            count            <= 2'd0;
            out_instruction  <= 8'h00;
            out_pc           <= 8'h00;
            tail_instruction <= 8'h00;
            tail_pc          <= 8'h00;
        end else if (redirect) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) begin
                        out_instruction <= instruction;
                        out_pc          <= pc;
                    end else begin
                        tail_instruction <= instruction;
                        tail_pc          <= pc;
                    end
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) begin
                        out_instruction <= tail_instruction;
                        out_pc          <= tail_pc;
                    end
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        out_instruction <= instruction;
                        out_pc          <= pc;
                    end else begin
                        out_instruction  <= tail_instruction;
                        out_pc           <= tail_pc;
                        tail_instruction <= instruction;
                        tail_pc          <= pc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: a queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized phase.
module tb_instr_fetch;

    localparam int         MEM_DEPTH = 32;
    localparam logic [7:0] RESET_PC  = 8'h00;

    logic       clk = 1'b0;
    logic       clear;
    logic [7:0] address;
    logic [7:0] instruction;
    logic       halt;
    logic       redirect;
    logic [7:0] redirect_target;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_instruction;
    logic [7:0] out_pc;
    logic       fault;

    logic [7:0] mem [256];

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] pc;
        logic [7:0] ins;
    } entry_t;

    entry_t m_q[$];
    int     m_pc;
    bit     m_fault;
    bit     model_ready = 1'b0;

    instr_fetch #(.MEM_DEPTH(MEM_DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk),
        .clear(clear),
        .address(address),
        .instruction(instruction),
        .halt(halt),
        .redirect(redirect),
        .redirect_target(redirect_target),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_instruction(out_instruction),
        .out_pc(out_pc),
        .fault(fault)
    );

    always #5 clk = ~clk;

    assign instruction = mem[address];

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic clr, input logic hlt, input logic rdr,
                                 input logic [7:0] tgt, input logic rdy);
        clear           = clr;
        halt            = hlt;
        redirect        = rdr;
        redirect_target = tgt;
        out_ready       = rdy;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    // Reference model: a queue of fetched entries plus a PC that wraps modulo the depth.
    always @(posedge clk) begin
        bit do_pop;
        bit do_fetch;
        if (clear) begin
            m_pc    = int'(RESET_PC);
            m_fault = 1'b0;
            m_q.delete();
            model_ready = 1'b1;
        end else if (model_ready) begin
            do_pop = (m_q.size() > 0) && out_ready;
            if (redirect) begin
                m_q.delete();
                if (int'(redirect_target) < MEM_DEPTH) m_pc = int'(redirect_target);
                else m_fault = 1'b1;
            end else begin
                do_fetch = !halt && !m_fault && ((m_q.size() < 2) || do_pop);
                if (do_pop) void'(m_q.pop_front());
                if (do_fetch) begin
                    m_q.push_back('{pc: 8'(m_pc), ins: mem[m_pc]});
                    m_pc = (m_pc + 1) % MEM_DEPTH;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (model_ready) begin
            checkOutput("address", address, 8'(m_pc));
            checkOutput("fault", {7'b0, fault}, {7'b0, m_fault});
            checkOutput("out_valid", {7'b0, out_valid}, {7'b0, m_q.size() > 0});
            if (m_q.size() > 0) begin
                checkOutput("out_pc", out_pc, m_q[0].pc);
                checkOutput("out_instruction", out_instruction, m_q[0].ins);
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        for (int i = 0; i < 8; i++) mem[i] = 8'hC1;
        mem[8] = 8'hC3;
        mem[9] = 8'hC3;
        clear = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_target = 8'h00; out_ready = 1'b1;
        @(negedge clk);
        #1;

        // reset state
        applyStimulus(1, 0, 0, 8'h00, 1);
        checkOutput("rst_address", address, 8'h00);
        checkOutput("rst_valid", {7'b0, out_valid}, 8'h00);
        checkOutput("rst_out_pc", out_pc, 8'h00);
        checkOutput("rst_out_ins", out_instruction, 8'h00);
        checkOutput("rst_fault", {7'b0, fault}, 8'h00);

        // reset-then-stream
        applyStimulus(0, 0, 0, 8'h00, 1);
        for (int k = 0; k < 10; k++) begin
            checkOutput("stream_valid", {7'b0, out_valid}, 8'h01);
            checkOutput("stream_pc", out_pc, 8'(k));
            checkOutput("stream_ins", out_instruction, (k >= 8) ? 8'hC3 : 8'hC1);
            applyStimulus(0, 0, 0, 8'h00, 1);
        end

        // backpressure from reset
        applyStimulus(1, 0, 0, 8'h00, 0);
        for (int k = 0; k < 5; k++) applyStimulus(0, 0, 0, 8'h00, 0);
        checkOutput("bp_address", address, 8'h02);
        checkOutput("bp_head", out_pc, 8'h00);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("bp_order1", out_pc, 8'h01);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("bp_order2", out_pc, 8'h02);

        // wrap around the end of memory
        applyStimulus(0, 0, 1, 8'd30, 1);
        checkOutput("wrap_flush", {7'b0, out_valid}, 8'h00);
        checkOutput("wrap_address", address, 8'd30);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("wrap_pc30", out_pc, 8'd30);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("wrap_pc31", out_pc, 8'd31);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("wrap_pc0", out_pc, 8'd0);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("wrap_pc1", out_pc, 8'd1);

        // redirect with a pop while the buffer is full
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkOutput("full_address", address, 8'd3);
        applyStimulus(0, 0, 1, 8'd5, 1);
        checkOutput("rdfull_valid", {7'b0, out_valid}, 8'h00);
        checkOutput("rdfull_address", address, 8'd5);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("rdfull_head", out_pc, 8'd5);

        // halt mid-stream
        applyStimulus(0, 0, 0, 8'h00, 0);
        checkOutput("pre_halt_address", address, 8'd7);
        applyStimulus(0, 1, 0, 8'h00, 1);
        checkOutput("halt_drain_head", out_pc, 8'd6);
        checkOutput("halt_address1", address, 8'd7);
        applyStimulus(0, 1, 0, 8'h00, 1);
        checkOutput("halt_drained", {7'b0, out_valid}, 8'h00);
        applyStimulus(0, 1, 0, 8'h00, 1);
        checkOutput("halt_address3", address, 8'd7);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("resume_head", out_pc, 8'd7);
        checkOutput("resume_address", address, 8'd8);

        // out-of-range redirect target
        applyStimulus(0, 0, 1, 8'h40, 1);
        checkOutput("bad_fault", {7'b0, fault}, 8'h01);
        checkOutput("bad_valid", {7'b0, out_valid}, 8'h00);
        checkOutput("bad_address", address, 8'd8);
        applyStimulus(0, 0, 0, 8'h00, 1);
        applyStimulus(0, 0, 0, 8'h00, 1);
        checkOutput("bad_frozen", address, 8'd8);
        checkOutput("bad_sticky", {7'b0, fault}, 8'h01);
        applyStimulus(1, 0, 1, 8'd9, 1);
        checkOutput("clr_fault", {7'b0, fault}, 8'h00);
        checkOutput("clr_address", address, RESET_PC);

        // randomized phase, checked by the model every cycle
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        for (int n = 0; n < 3000; n++) begin
            logic [7:0] tgt;
            tgt = ($urandom_range(7, 0) == 0) ? 8'($urandom_range(255, MEM_DEPTH))
                                              : 8'($urandom_range(MEM_DEPTH - 1, 0));
            applyStimulus($urandom_range(63, 0) == 0, $urandom_range(4, 0) == 0,
                          $urandom_range(15, 0) == 0, tgt, $urandom_range(9, 0) < 7);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
